tictactoe_frame_renderer: RTL and testbench
===========================================

# tictactoe_frame_renderer

Pixel-stream renderer downstream of the static 135×80 grid bitmap. It generates 640×480@60 VGA timing and fetches bitmap bits scaled up by `SCALE`. It overlays X/O glyphs for the 3×3 board held in the left 81 bitmap columns and drives registered RGB and sync to the DAC/HDMI encoder. Board contents arrive through a valid/ready handshake and are applied only at frame boundaries, so no frame ever shows a torn board.

## Interface
- `SCALE`, 4: bitmap-to-screen scale; must be a power of two.
- `X0`, 50: screen column of bitmap column 0.
- `Y0`, 80: screen row of bitmap row 0.
- `clk`  in  1  25.175 MHz pixel clock
- `reset_n`  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low)
- `bitmap`  in  135×80 (`[134:0] [0:79]`)  grid image; 1 = background, 0 = line; bit 134 is leftmost
- `board_in`  in  18  nine 2-bit cells, cell k = `[2k+1:2k]`, k = 3·row + col; 00 empty, 01 X, 10 O, 11 rendered empty
- `board_valid`  in  1  `board_in` valid
- `board_ready`  out  1  pending slot free
- `cursor`  in  4  cursor cell index 0–8; values 9–15 mean no cursor
- `hsync`, `vsync`  out  1  active low
- `de`  out  1  active video
- `red`, `green`, `blue`  out  4 each
- `frame_start`  out  1  one-cycle pulse, aligned with pixel (0,0) on the outputs

## Operation
- Counters: `hc` 0–799, `vc` 0–524. `hc` wraps to 0 at 799 and `vc` increments; `vc` wraps to 0 at 524.
- Sync and active region:
  - `hsync` is low for `hc` 656–751.
  - `vsync` is low for `vc` 490–491.
  - `de` is high for `hc`<640 && `vc`<480.
- Stage 1, address:
  - In-image when `X0`≤hc<`X0`+135·`SCALE` and `Y0`≤vc<`Y0`+80·`SCALE`.
  - `bx`=(hc−X0)>>log2(SCALE), `by`=(vc−Y0)>>log2(SCALE).
  - Cell column: bx 0–26 → 0, 27–53 → 1, 54–80 → 2, ≥81 → none.
  - Cell row start: by 0–26 → 1, 27–53 → 27, 54–79 → 54.
  - Local glyph coordinates are (bx−27·col, by−start); a result outside 0–25 means no glyph.
  - The division is implemented with comparators only.
- Stage 2, colour, priority high to low:
  1. `de`=0 → 000.
  2. Not in-image → 222.
  3. Bitmap bit 0 → 000.
  4. Glyph pixel set and cell = X → F00.
  5. Glyph pixel set and cell = O → 00F.
  6. Otherwise → FFF.
- Board handshake:
  - Transfer occurs on `board_valid`&&`board_ready`: `board_in` → pending, and `board_ready` drops the next cycle.
  - At `hc`=0, `vc`=480 with pending full: pending → displayed, and `board_ready` rises the next cycle.
  - Transfers cannot coincide with the apply cycle, because `ready` is low there.
  - Without a new transfer, the displayed board holds indefinitely.
- `cursor` is sampled at the same `vc`=480 point every frame.
- Reset values:
  - `hc`=`vc`=0.
  - `hsync`=`vsync`=1.
  - `de`=0, RGB=000, `frame_start`=0.
  - `board_ready`=1, pending empty.
  - Displayed board all 00.
  - Sampled cursor = 15.
- Reset asserted mid-frame restarts the counters at (0,0) with no partial-line flush.

## Timing
- All outputs are registered. Latency from counter value to output is exactly 2 cycles.
- `hsync`, `vsync`, `de` and `frame_start` are delayed by 2 cycles to stay aligned with RGB.
- First `frame_start` pulse: 2 cycles after reset release.
- Line = 800 cycles, frame = 420 000 cycles.
- Board update visible in the first frame after the next `vc`=480 apply point. Worst case from transfer: ≈1 frame + 45 lines.

## Configuration
- `TTT_RENDER_CURSOR_EN` defined: in-image pixels of the sampled cursor cell that would be FFF render as FF0. Line and glyph colours are unchanged.
- Undefined: the `cursor` input is ignored and the sampled-cursor register is not generated.

## Structure
- Shared package `tictactoe_pkg`:
  - `cell_t` enum (EMPTY, X, O, RSVD).
  - `board_t` packed [8:0] array of `cell_t`.
  - Timing constants (H_ACTIVE 640, H_TOTAL 800, HS_START 656, HS_END 751, V_ACTIVE 480, V_TOTAL 525, VS_START 490, VS_END 491).
  - Colour constants.
  - Cell bounds 27/54/81.
- Sub-module `tictactoe_mark_rom`: combinational 26×26 X and O glyph lookup, inputs local x/y and glyph select, output one bit.

## Test plan
- Reset, run 2 frames:
  - `hsync` low 96 cycles every 800.
  - `vsync` low 1600 cycles every 420 000.
  - `frame_start` period 420 000.
  - `de` high 640×480 per frame.
- Bitmap from the grid image, board all empty: pixel (50,80) = 000 (row 0 line); (54,84) = FFF; (20,20) = 222; (50+26·4, 200) = 000 (vertical divider).
- Transfer board with cell 0 = X and cell 4 = O mid-frame: the current frame is unchanged. The next frame shows F00 at cell 0 glyph pixels and 00F at cell 4 glyph pixels. `board_ready` is low from the transfer until the cycle after `vc`=480.
- `board_valid` held high continuously: exactly one transfer per frame, with no transfer on the apply cycle.
- `reset_n` low for 1 cycle at `hc`=300, `vc`=200: the next cycle has counters at (0,0), outputs at reset values for 2 cycles, then `frame_start`, and the displayed board is cleared.
- With `TTT_RENDER_CURSOR_EN`, `cursor`=8: background pixels of cell 8 are FF0. `cursor`=12 gives no highlight. Without the macro, `cursor`=8 gives no highlight.

Source files
------------

// File: rtl/tictactoe_pkg.sv
// Shared types and constants for the tic-tac-toe VGA frame renderer.
package tictactoe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        X     = 2'b01,
        O     = 2'b10,
        RSVD  = 2'b11
    } cell_t;

    typedef cell_t [8:0] board_t;

    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] H_TOTAL  = 10'd800;
    localparam logic [9:0] HS_START = 10'd656;
    localparam logic [9:0] HS_END   = 10'd751;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] V_TOTAL  = 10'd525;
    localparam logic [9:0] VS_START = 10'd490;
    localparam logic [9:0] VS_END   = 10'd491;

    localparam logic [11:0] COL_BLACK  = 12'h000;
    localparam logic [11:0] COL_GREY   = 12'h222;
    localparam logic [11:0] COL_WHITE  = 12'hFFF;
    localparam logic [11:0] COL_RED    = 12'hF00;
    localparam logic [11:0] COL_BLUE   = 12'h00F;
    localparam logic [11:0] COL_YELLOW = 12'hFF0;

    localparam logic [7:0] CELL_B1 = 8'd27;
    localparam logic [7:0] CELL_B2 = 8'd54;
    localparam logic [7:0] CELL_B3 = 8'd81;
    localparam logic [7:0] GLYPH_N = 8'd26;

    function automatic logic [3:0] cell_index(input logic [1:0] row,
                                              input logic [1:0] col);
        return {1'b0, row, 1'b0} + {2'b00, row} + {2'b00, col};
    endfunction

endpackage

// File: rtl/tictactoe_mark_rom.sv
// Combinational 26x26 glyph lookup: diagonal cross for X, ring for O.
module tictactoe_mark_rom
    import tictactoe_pkg::*;
(
    input  logic [4:0] i_x,
    input  logic [4:0] i_y,
    input  cell_t      i_cell,
    output logic       o_pix
);

    logic [5:0]  w_ax;
    logic [5:0]  w_ay;
    logic [5:0]  w_sum;
    logic [10:0] w_r2;
    logic        w_box;
    logic        w_x_hit;
    logic        w_o_hit;

    // Distances from the glyph centre (12.5,12.5) in half-pixel units.
    assign w_ax = (i_x >= 5'd13) ? {i_x, 1'b0} - 6'd25 : 6'd25 - {i_x, 1'b0};
    assign w_ay = (i_y >= 5'd13) ? {i_y, 1'b0} - 6'd25 : 6'd25 - {i_y, 1'b0};
    assign w_r2 = {5'd0, w_ax} * {5'd0, w_ax} + {5'd0, w_ay} * {5'd0, w_ay};

    assign w_sum   = {1'b0, i_x} + {1'b0, i_y};
    assign w_box   = (i_x >= 5'd3) && (i_x <= 5'd22) &&
                     (i_y >= 5'd3) && (i_y <= 5'd22);
    assign w_x_hit = w_box &&
                     ((5'(i_x - i_y + 5'd1) <= 5'd2) ||
                      ((w_sum >= 6'd24) && (w_sum <= 6'd26)));
    assign w_o_hit = (w_r2 >= 11'd324) && (w_r2 <= 11'd484);

    always_comb begin
        o_pix = 1'b0;
        unique case (i_cell)
            X:       o_pix = w_x_hit;
            O:       o_pix = w_o_hit;
            default: o_pix = 1'b0;
        endcase
    end

endmodule

// File: rtl/tictactoe_frame_renderer.sv
// 640x480@60 renderer: scaled grid bitmap, X/O overlay, frame-synchronous board.
// TTT_RENDER_CURSOR_EN adds a yellow highlight of the sampled cursor cell.
module tictactoe_frame_renderer
    import tictactoe_pkg::*;
#(
    parameter int SCALE = 4,
    parameter int X0    = 50,
    parameter int Y0    = 80
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [134:0] bitmap [0:79],
    input  logic [17:0]  board_in,
    input  logic         board_valid,
    output logic         board_ready,
    input  logic [3:0]   cursor,
    output logic         hsync,
    output logic         vsync,
    output logic         de,
    output logic [3:0]   red,
    output logic [3:0]   green,
    output logic [3:0]   blue,
    output logic         frame_start
);

    localparam int         SH = $clog2(SCALE);
    localparam logic [9:0] XL = 10'(X0);
    localparam logic [9:0] XH = 10'(X0 + 135 * SCALE);
    localparam logic [9:0] YL = 10'(Y0);
    localparam logic [9:0] YH = 10'(Y0 + 80 * SCALE);

    logic [9:0] r_hc, r_vc;
    board_t     r_disp, r_pend;
    logic       r_ready;
    logic       w_apply;

    assign w_apply     = (r_hc == 10'd0) && (r_vc == V_ACTIVE);
    assign board_ready = r_ready;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (r_hc == H_TOTAL - 10'd1) begin
            r_hc <= '0;
            r_vc <= (r_vc == V_TOTAL - 10'd1) ? 10'd0 : r_vc + 10'd1;
        end else begin
            r_hc <= r_hc + 10'd1;
        end
    end

    // The pending slot is full exactly when ready is low.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ready <= 1'b1;
            r_pend  <= board_t'(18'd0);
            r_disp  <= board_t'(18'd0);
        end else if (w_apply && !r_ready) begin
            r_disp  <= r_pend;
            r_ready <= 1'b1;
        end else if (board_valid && r_ready) begin
            r_pend  <= board_t'(board_in);
            r_ready <= 1'b0;
        end
    end

    logic [9:0] w_dx, w_dy;
    logic [7:0] w_bx, w_by8, w_lx, w_ly, w_start;
    logic [6:0] w_by;
    logic [1:0] w_col, w_row;
    logic [3:0] w_idx;
    logic       w_in_img, w_col_ok, w_gly_ok, w_bit, w_mark;
    cell_t      w_cell;

    assign w_in_img = (r_hc >= XL) && (r_hc < XH) && (r_vc >= YL) && (r_vc < YH);
    assign w_dx     = r_hc - XL;
    assign w_dy     = r_vc - YL;
    assign w_bx     = 8'(w_dx >> SH);
    assign w_by     = 7'(w_dy >> SH);
    assign w_by8    = {1'b0, w_by};

    always_comb begin
        w_col_ok = 1'b1;
        w_col    = 2'd0;
        w_lx     = w_bx;
        unique case (1'b1)
            (w_bx < CELL_B1): begin
                w_col = 2'd0;
                w_lx  = w_bx;
            end
            (w_bx >= CELL_B1 && w_bx < CELL_B2): begin
                w_col = 2'd1;
                w_lx  = w_bx - CELL_B1;
            end
            (w_bx >= CELL_B2 && w_bx < CELL_B3): begin
                w_col = 2'd2;
                w_lx  = w_bx - CELL_B2;
            end
            default: w_col_ok = 1'b0;
        endcase
    end

    // Row 0 glyphs start one bitmap row down, below the top border line.
    always_comb begin
        w_row   = 2'd2;
        w_start = CELL_B2;
        unique case (1'b1)
            (w_by8 < CELL_B1): begin
                w_row   = 2'd0;
                w_start = 8'd1;
            end
            (w_by8 >= CELL_B1 && w_by8 < CELL_B2): begin
                w_row   = 2'd1;
                w_start = CELL_B1;
            end
            default: begin
                w_row   = 2'd2;
                w_start = CELL_B2;
            end
        endcase
    end

    assign w_ly     = w_by8 - w_start;
    assign w_gly_ok = w_col_ok && (w_by8 >= w_start) &&
                      (w_lx < GLYPH_N) && (w_ly < GLYPH_N);
    assign w_idx    = cell_index(w_row, w_col);
    assign w_cell   = w_gly_ok ? r_disp[w_idx] : EMPTY;
    assign w_bit    = bitmap[w_by][8'd134 - w_bx];

    tictactoe_mark_rom u_rom (
        .i_x    (w_lx[4:0]),
        .i_y    (w_ly[4:0]),
        .i_cell (w_cell),
        .o_pix  (w_mark)
    );

    logic r1_de, r1_hs, r1_vs, r1_fs, r1_in, r1_bit, r1_mark, r1_cur;
    cell_t r1_cell;
    logic w_cur_hit;

`ifdef TTT_RENDER_CURSOR_EN
    logic [3:0] r_cursor;

    always_ff @(posedge clk) begin
        if (!reset_n)
            r_cursor <= 4'd15;
        else if (w_apply)
            r_cursor <= cursor;
    end

    assign w_cur_hit = w_in_img && w_col_ok && (w_idx == r_cursor);
`else
    logic w_unused_cursor;
    assign w_unused_cursor = ^cursor;
    assign w_cur_hit       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r1_de   <= 1'b0;
            r1_hs   <= 1'b1;
            r1_vs   <= 1'b1;
            r1_fs   <= 1'b0;
            r1_in   <= 1'b0;
            r1_bit  <= 1'b0;
            r1_mark <= 1'b0;
            r1_cur  <= 1'b0;
            r1_cell <= EMPTY;
        end else begin
            r1_de   <= (r_hc < H_ACTIVE) && (r_vc < V_ACTIVE);
            r1_hs   <= !((r_hc >= HS_START) && (r_hc <= HS_END));
            r1_vs   <= !((r_vc >= VS_START) && (r_vc <= VS_END));
            r1_fs   <= (r_hc == 10'd0) && (r_vc == 10'd0);
            r1_in   <= w_in_img;
            r1_bit  <= w_bit;
            r1_mark <= w_mark;
            r1_cur  <= w_cur_hit;
            r1_cell <= w_cell;
        end
    end

    logic [11:0] w_rgb;

    always_comb begin
        w_rgb = COL_WHITE;
        if (!r1_de)
            w_rgb = COL_BLACK;
        else if (!r1_in)
            w_rgb = COL_GREY;
        else if (!r1_bit)
            w_rgb = COL_BLACK;
        else if (r1_mark && r1_cell == X)
            w_rgb = COL_RED;
        else if (r1_mark && r1_cell == O)
            w_rgb = COL_BLUE;
        else if (r1_cur)
            w_rgb = COL_YELLOW;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            frame_start <= 1'b0;
            {red, green, blue} <= COL_BLACK;
        end else begin
            hsync       <= r1_hs;
            vsync       <= r1_vs;
            de          <= r1_de;
            frame_start <= r1_fs;
            {red, green, blue} <= w_rgb;
        end
    end

endmodule

// File: tb/tb_tictactoe_frame_renderer.sv
// Directed bench for tictactoe_frame_renderer: sync, pixels, board handshake, reset.
module tb_tictactoe_frame_renderer;

    localparam int FRAME = 420000;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [134:0] bm [0:79];
    logic [17:0]  board_in;
    logic         board_valid;
    logic         board_ready;
    logic [3:0]   cursor;
    logic         hsync, vsync, de, frame_start;
    logic [3:0]   red, green, blue;
    logic [11:0]  rgb;

    int pos;
    int hs_lo, vs_lo, de_hi, fs_n, xfer_n;
    int n_cmp, n_err;

    logic [11:0] exp_cur;

    assign rgb = {red, green, blue};

    always #5 clk = ~clk;

    tictactoe_frame_renderer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bitmap      (bm),
        .board_in    (board_in),
        .board_valid (board_valid),
        .board_ready (board_ready),
        .cursor      (cursor),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_start (frame_start)
    );

    // pos = linear index of the pixel currently shown on the outputs.
    task automatic tick();
        if (board_valid && board_ready) xfer_n++;
        @(posedge clk);
        #1;
        pos++;
        if (pos >= 0 && pos < FRAME) begin
            if (!hsync) hs_lo++;
            if (!vsync) vs_lo++;
            if (de) de_hi++;
            if (frame_start) fs_n++;
        end
    endtask

    task automatic go(input int f, input int h, input int v);
        int t;
        t = f * FRAME + v * 800 + h;
        while (pos < t) tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (hsync !== 1'b1) begin n_err++; $display("FAIL rst_hsync got %b want 1", hsync); end
        n_cmp++; if (vsync !== 1'b1) begin n_err++; $display("FAIL rst_vsync got %b want 1", vsync); end
        n_cmp++; if (de !== 1'b0) begin n_err++; $display("FAIL rst_de got %b want 0", de); end
        n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL rst_rgb got %h want 000", rgb); end
        n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL rst_fs got %b want 0", frame_start); end
        n_cmp++; if (board_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", board_ready); end
        reset_n = 1'b1;
        pos = -2;
        hs_lo = 0; vs_lo = 0; de_hi = 0; fs_n = 0; xfer_n = 0;
        tick();
        n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL fs_early got %b want 0", frame_start); end
        tick();
        n_cmp++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL fs_first got %b want 1", frame_start); end
        n_cmp++; if (de !== 1'b1) begin n_err++; $display("FAIL de_first got %b want 1", de); end
    endtask

    task automatic test_static();
        go(0, 20, 20);
        n_cmp++; if (rgb !== 12'h222) begin n_err++; $display("FAIL pix_outside got %h want 222", rgb); end
        go(0, 50, 80);
        n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL pix_row0_line got %h want 000", rgb); end
        go(0, 54, 84);
        n_cmp++; if (rgb !== 12'hFFF) begin n_err++; $display("FAIL pix_bg got %h want FFF", rgb); end
        go(0, 154, 88);
        n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL pix_vdiv got %h want 000", rgb); end
        go(0, 660, 88);
        n_cmp++; if (hsync !== 1'b0) begin n_err++; $display("FAIL hsync_low got %b want 0", hsync); end
        go(0, 700, 88);
        n_cmp++; if (de !== 1'b0 || rgb !== 12'h000) begin
            n_err++; $display("FAIL blank got de=%b rgb=%h want de=0 rgb=000", de, rgb);
        end
    endtask

    task automatic test_transfer();
        go(0, 0, 90);
        n_cmp++; if (board_ready !== 1'b1) begin n_err++; $display("FAIL ready_idle got %b want 1", board_ready); end
        board_in    = 18'h00201;
        board_valid = 1'b1;
        tick();
        n_cmp++; if (board_ready !== 1'b0) begin n_err++; $display("FAIL ready_drop got %b want 0", board_ready); end
        go(0, 98, 132);
        n_cmp++; if (rgb !== 12'hFFF) begin n_err++; $display("FAIL cur_frame_c0 got %h want FFF", rgb); end
        go(0, 170, 236);
        n_cmp++; if (rgb !== 12'hFFF) begin n_err++; $display("FAIL cur_frame_c4 got %h want FFF", rgb); end
        go(0, 798, 479);
        n_cmp++; if (board_ready !== 1'b0) begin n_err++; $display("FAIL ready_apply got %b want 0", board_ready); end
        tick();
        n_cmp++; if (board_ready !== 1'b1) begin n_err++; $display("FAIL ready_rise got %b want 1", board_ready); end
        tick();
        n_cmp++; if (board_ready !== 1'b0) begin n_err++; $display("FAIL ready_refill got %b want 0", board_ready); end
    endtask

    task automatic test_sync();
        go(1, 0, 0);
        n_cmp++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL fs_period got %b want 1", frame_start); end
        n_cmp++; if (hs_lo !== 50400) begin n_err++; $display("FAIL hsync_count got %0d want 50400", hs_lo); end
        n_cmp++; if (vs_lo !== 1600) begin n_err++; $display("FAIL vsync_count got %0d want 1600", vs_lo); end
        n_cmp++; if (de_hi !== 307200) begin n_err++; $display("FAIL de_count got %0d want 307200", de_hi); end
        n_cmp++; if (fs_n !== 1) begin n_err++; $display("FAIL fs_count got %0d want 1", fs_n); end
        xfer_n = 0;
    endtask

    task automatic test_glyphs();
`ifdef TTT_RENDER_CURSOR_EN
        exp_cur = 12'hFF0;
`else
        exp_cur = 12'hFFF;
`endif
        go(1, 98, 96);
        n_cmp++; if (rgb !== 12'hFFF) begin n_err++; $display("FAIL c0_bg got %h want FFF", rgb); end
        go(1, 98, 132);
        n_cmp++; if (rgb !== 12'hF00) begin n_err++; $display("FAIL c0_x got %h want F00", rgb); end
        go(1, 170, 236);
        n_cmp++; if (rgb !== 12'h00F) begin n_err++; $display("FAIL c4_o got %h want 00F", rgb); end
        go(1, 206, 236);
        n_cmp++; if (rgb !== 12'hFFF) begin n_err++; $display("FAIL c4_hole got %h want FFF", rgb); end
        go(1, 314, 344);
        n_cmp++; if (rgb !== exp_cur) begin n_err++; $display("FAIL c8_cursor got %h want %h", rgb, exp_cur); end
        go(1, 370, 344);
        n_cmp++; if (rgb !== 12'h000) begin n_err++; $display("FAIL c8_line got %h want 000", rgb); end
        cursor = 4'd12;
    endtask

    task automatic test_back_to_back();
        go(1, 798, 479);
        n_cmp++; if (board_ready !== 1'b0) begin n_err++; $display("FAIL b2b_apply_ready got %b want 0", board_ready); end
        go(2, 0, 0);
        n_cmp++; if (xfer_n !== 1) begin n_err++; $display("FAIL b2b_xfers got %0d want 1", xfer_n); end
        n_cmp++; if (board_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready got %b want 0", board_ready); end
    endtask

    task automatic test_cursor_off();
        go(2, 98, 96);
        n_cmp++; if (rgb !== 12'hFFF) begin n_err++; $display("FAIL nocur_bg got %h want FFF", rgb); end
        go(2, 98, 132);
        n_cmp++; if (rgb !== 12'hF00) begin n_err++; $display("FAIL hold_x got %h want F00", rgb); end
    endtask

    task automatic test_reset_mid();
        board_valid = 1'b0;
        go(2, 298, 200);
        reset_n = 1'b0;
        tick();
        n_cmp++; if (rgb !== 12'h000 || de !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_out got rgb=%h de=%b want 000 0", rgb, de);
        end
        n_cmp++; if (hsync !== 1'b1 || vsync !== 1'b1) begin
            n_err++; $display("FAIL mid_rst_sync got %b%b want 11", hsync, vsync);
        end
        n_cmp++; if (board_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready got %b want 1", board_ready); end
        reset_n = 1'b1;
        tick();
        n_cmp++; if (frame_start !== 1'b0 || de !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_hold got fs=%b de=%b want 0 0", frame_start, de);
        end
        tick();
        n_cmp++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL mid_rst_fs got %b want 1", frame_start); end
        pos = 0;
        go(0, 98, 132);
        n_cmp++; if (rgb !== 12'hFFF) begin n_err++; $display("FAIL mid_rst_board got %h want FFF", rgb); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        pos = 0;
        board_in = '0;
        board_valid = 1'b0;
        cursor = 4'd8;
        reset_n = 1'b0;
        for (int r = 0; r < 80; r++) begin
            bm[r] = '1;
            if (r == 0 || r == 26 || r == 53) bm[r] = '0;
            bm[r][134 - 26] = 1'b0;
            bm[r][134 - 53] = 1'b0;
            bm[r][134 - 80] = 1'b0;
        end
        test_reset();
        test_static();
        test_transfer();
        test_sync();
        test_glyphs();
        test_back_to_back();
        test_cursor_off();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
